// File: rtl/vxe_cu_intr_src_pkg.sv
// rtl/vxe_cu_intr_src_pkg.sv - shared FSM encodings and default parameters for the CU interrupt source
package vxe_cu_intr_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cu_state_e;

  localparam int DEF_NR_INT  = 4;
  localparam int DEF_ERR_BIT = 3;
  localparam int DEF_CNT_W   = 6;

  function automatic logic is_busy(cu_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/vxe_cu_intr_src_if.sv
// rtl/vxe_cu_intr_src_if.sv - decoder/issue handshakes and interrupt-unit outputs of the CU interrupt source
interface vxe_cu_intr_src_if #(
  parameter int NR_INT = 4,
  parameter int CNT_W  = 6
);
  logic              i_start;
  logic              i_intr_vld;
  logic [NR_INT-1:0] i_intr_vec;
  logic              o_intr_rdy;
  logic              i_stop_vld;
  logic              o_stop_rdy;
  logic              i_op_vld;
  logic              o_op_rdy;
  logic              i_op_done;
  logic              i_err;
  logic              o_cu_busy;
  logic [NR_INT-1:0] o_cu_intr;
  logic [CNT_W-1:0]  o_outst;

  modport master (
    output i_start, i_intr_vld, i_intr_vec, i_stop_vld, i_op_vld, i_op_done, i_err,
    input  o_intr_rdy, o_stop_rdy, o_op_rdy, o_cu_busy, o_cu_intr, o_outst
  );

  modport slave (
    input  i_start, i_intr_vld, i_intr_vec, i_stop_vld, i_op_vld, i_op_done, i_err,
    output o_intr_rdy, o_stop_rdy, o_op_rdy, o_cu_busy, o_cu_intr, o_outst
  );
endinterface

// File: rtl/vxe_cu_intr_src_outst_cnt.sv
// rtl/vxe_cu_intr_src_outst_cnt.sv - saturating-by-gating up/down counter of outstanding operations
module vxe_cu_intr_src_outst_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             zero
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic inc_ok;
  logic dec_ok;

  assign full   = (cnt == CNT_MAX);
  assign zero   = (cnt == '0);
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // A completion with nothing outstanding means the functional units and CU disagree.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && zero));

endmodule

// File: rtl/vxe_cu_intr_src.sv
// rtl/vxe_cu_intr_src.sv - tracks one CU program run and presents accumulated interrupt bits when it ends
module vxe_cu_intr_src
  import vxe_cu_intr_src_pkg::*;
#(
  parameter int NR_INT  = DEF_NR_INT,
  parameter int ERR_BIT = DEF_ERR_BIT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  vxe_cu_intr_src_if.slave   bus
);
  cu_state_e         state;
  cu_state_e         state_nxt;
  logic [NR_INT-1:0] pending;
  logic [NR_INT-1:0] pending_nxt;
  logic [NR_INT-1:0] cu_intr_q;
  logic              busy_q;
  logic              run_q;
  logic              intr_acc;
  logic              stop_acc;
  logic              op_acc;
  logic              err_hit;
  logic              cnt_full;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt;

  assign intr_acc = bus.i_intr_vld && run_q;
  assign stop_acc = bus.i_stop_vld && run_q;
  assign op_acc   = bus.i_op_vld && run_q && !cnt_full;
  assign err_hit  = bus.i_err && busy_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_start) state_nxt = ST_RUN;
      ST_RUN:   if (stop_acc || bus.i_err) state_nxt = ST_DRAIN;
      ST_DRAIN: if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // DONE is the last cycle of a run, so pending empties as the FSM returns to IDLE.
  always_comb begin
    pending_nxt = pending;
    if (intr_acc) pending_nxt = pending_nxt | bus.i_intr_vec;
    if (err_hit) pending_nxt[ERR_BIT] = 1'b1;
    if (state == ST_DONE) pending_nxt = '0;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
      cu_intr_q <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      busy_q    <= is_busy(state_nxt);
      run_q     <= (state_nxt == ST_RUN);
      cu_intr_q <= (state_nxt == ST_DONE) ? pending_nxt : '0;
    end
  end

  vxe_cu_intr_src_outst_cnt #(
    .CNT_W (CNT_W)
  ) u_outst_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (op_acc),
    .dec  (bus.i_op_done),
    .cnt  (cnt),
    .full (cnt_full),
    .zero (cnt_zero)
  );

  assign bus.o_intr_rdy = run_q;
  assign bus.o_stop_rdy = run_q;
  assign bus.o_op_rdy   = run_q && !cnt_full;
  assign bus.o_cu_busy  = busy_q;
  assign bus.o_cu_intr  = cu_intr_q;
  assign bus.o_outst    = cnt;

endmodule
